// File: rtl/requester_tag_queue_rp.sv
// Generic synchronous FIFO used for the replay tag queue.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; the owner must respect empty/full.
module requester_tag_queue_rp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    // DEPTH is a power of two, so pointers wrap naturally
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_dat = mem[rd_ptr];

    // Storage array carries no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// Outbound read tag manager: allocates lowest free tag, holds addr/len per tag, replays errored requests.
// Latency: accepted request or queued replay appears on issue_* one cycle after it is loaded; completion effects show next cycle.
// Backpressure: issue slot holds while issue_ready is low; req_ready drops while slot is blocked, replays wait or no tag is free.
module requester_tag_queue_rp #(
    parameter int NB_TAGS    = 32,
    parameter int MAX_REPLAY = 3,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  srst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [10:0]           req_len,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [7:0]            issue_tag,
    output logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [10:0]           issue_len,
    output logic                  issue_replay,
    input  logic [7:0]            select_tag,
    input  logic                  select_tag_valid,
    input  logic                  select_tag_done,
    input  logic                  select_replay_cfg,
    output logic [8:0]            outstanding_cnt,
    output logic                  abort_valid,
    output logic [7:0]            abort_tag,
    output logic                  spurious_cpl,
    output logic                  idle
);
    localparam int TW = (NB_TAGS > 1) ? $clog2(NB_TAGS) : 1;

    // Tag table. q_entry: tag owns a slot in the replay FIFO.
    // q_live: that slot should still produce a replay (cleared if the tag is freed meanwhile).
    logic [NB_TAGS-1:0]    busy;
    logic [NB_TAGS-1:0]    q_entry;
    logic [NB_TAGS-1:0]    q_live;
    logic [ADDR_WIDTH-1:0] tag_addr [NB_TAGS];
    logic [10:0]           tag_len  [NB_TAGS];
    logic [3:0]            tag_rcnt [NB_TAGS];

    logic          slot_free;
    logic          any_free;
    logic [TW-1:0] free_tag;
    logic          accept;
    logic          fifo_empty;
    logic          fifo_full;
    logic [TW-1:0] head_tag;
    logic          pop;
    logic          head_kill;
    logic          load_replay;
    logic          cpl_in_range;
    logic [TW-1:0] cpl_idx;
    logic          cpl_hit;
    logic          cpl_spur;
    logic          cpl_err;
    logic          cpl_abort;
    logic          cpl_retry;
    logic          cpl_push;
    logic          cpl_free;

    // Lowest-index free tag from the registered busy vector, so a tag freed this cycle is not reused until next
    always_comb begin
        any_free = 1'b0;
        free_tag = '0;
        for (int i = NB_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free = 1'b1;
                free_tag = TW'(i);
            end
        end
    end

    assign slot_free = !issue_valid || issue_ready;
    assign req_ready = slot_free && fifo_empty && any_free;
    assign accept    = req_valid && req_ready;

    // Completion decode; anything hitting a free or out-of-range tag is only reported
    assign cpl_in_range = ({1'b0, select_tag} < 9'(NB_TAGS));
    assign cpl_idx      = select_tag[TW-1:0];
    assign cpl_hit      = select_tag_valid && cpl_in_range && busy[cpl_idx];
    assign cpl_spur     = select_tag_valid && !cpl_hit;
    assign cpl_err      = cpl_hit && select_replay_cfg;
    assign cpl_abort    = cpl_err && (tag_rcnt[cpl_idx] == 4'(MAX_REPLAY));
    assign cpl_retry    = cpl_err && !cpl_abort;
    assign cpl_free     = cpl_abort || (cpl_hit && !select_replay_cfg && select_tag_done);

    // A head entry is popped whenever the slot can load; stale entries (tag freed while queued) are dropped
    assign pop         = slot_free && !fifo_empty;
    assign head_kill   = cpl_free && (cpl_idx == head_tag);
    assign load_replay = pop && q_live[head_tag] && !head_kill;
    // A tag already holding a FIFO slot is not pushed again, unless that slot is leaving this cycle
    assign cpl_push    = cpl_retry && !fifo_full &&
                         (!q_entry[cpl_idx] || (pop && (head_tag == cpl_idx)));

    requester_tag_queue_rp_fifo #(
        .WIDTH (TW),
        .DEPTH (NB_TAGS)
    ) u_replay_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (srst),
        .push_vld (cpl_push),
        .push_dat (cpl_idx),
        .pop_rdy  (pop),
        .pop_dat  (head_tag),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Request payload capture on the accept edge; contents only matter while the tag is busy
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_addr[free_tag] <= req_addr;
            tag_len[free_tag]  <= req_len;
        end
    end

    // Per-tag busy, replay count and queue bookkeeping; later assignments take priority for the same tag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy    <= '0;
            q_entry <= '0;
            q_live  <= '0;
            for (int i = 0; i < NB_TAGS; i++) begin
                tag_rcnt[i] <= '0;
            end
        end else if (srst) begin
            busy    <= '0;
            q_entry <= '0;
            q_live  <= '0;
            for (int i = 0; i < NB_TAGS; i++) begin
                tag_rcnt[i] <= '0;
            end
        end else begin
            if (accept) begin
                busy[free_tag]     <= 1'b1;
                tag_rcnt[free_tag] <= '0;
            end
            if (pop) begin
                q_entry[head_tag] <= 1'b0;
                q_live[head_tag]  <= 1'b0;
            end
            if (cpl_retry) begin
                tag_rcnt[cpl_idx] <= tag_rcnt[cpl_idx] + 4'd1;
                q_live[cpl_idx]   <= 1'b1;
                if (cpl_push) begin
                    q_entry[cpl_idx] <= 1'b1;
                end
            end
            if (cpl_free) begin
                busy[cpl_idx]     <= 1'b0;
                tag_rcnt[cpl_idx] <= '0;
                q_live[cpl_idx]   <= 1'b0;
            end
        end
    end

    // Single issue slot: replays win over new requests, contents frozen while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_valid  <= 1'b0;
            issue_tag    <= '0;
            issue_addr   <= '0;
            issue_len    <= '0;
            issue_replay <= 1'b0;
        end else if (srst) begin
            issue_valid  <= 1'b0;
            issue_tag    <= '0;
            issue_addr   <= '0;
            issue_len    <= '0;
            issue_replay <= 1'b0;
        end else if (slot_free) begin
            if (load_replay) begin
                issue_valid  <= 1'b1;
                issue_tag    <= 8'(head_tag);
                issue_addr   <= tag_addr[head_tag];
                issue_len    <= tag_len[head_tag];
                issue_replay <= 1'b1;
            end else if (accept) begin
                issue_valid  <= 1'b1;
                issue_tag    <= 8'(free_tag);
                issue_addr   <= req_addr;
                issue_len    <= req_len;
                issue_replay <= 1'b0;
            end else begin
                issue_valid  <= 1'b0;
            end
        end
    end

    // Outstanding count and one-cycle status pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_cnt <= '0;
            abort_valid     <= 1'b0;
            abort_tag       <= '0;
            spurious_cpl    <= 1'b0;
        end else if (srst) begin
            outstanding_cnt <= '0;
            abort_valid     <= 1'b0;
            abort_tag       <= '0;
            spurious_cpl    <= 1'b0;
        end else begin
            outstanding_cnt <= outstanding_cnt + 9'(accept) - 9'(cpl_free);
            abort_valid     <= cpl_abort;
            spurious_cpl    <= cpl_spur;
            if (cpl_abort) begin
                abort_tag <= select_tag;
            end
        end
    end

    assign idle = (outstanding_cnt == '0) && !issue_valid;
endmodule

// File: tb/tb_requester_tag_queue_rp.sv
module tb_requester_tag_queue_rp;
    localparam int NT = 32;
    localparam int MR = 3;
    localparam int AW = 64;

    logic          clk;
    logic          rstn;
    logic          srst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [10:0]   req_len;
    logic          issue_valid;
    logic          issue_ready;
    logic [7:0]    issue_tag;
    logic [AW-1:0] issue_addr;
    logic [10:0]   issue_len;
    logic          issue_replay;
    logic [7:0]    select_tag;
    logic          select_tag_valid;
    logic          select_tag_done;
    logic          select_replay_cfg;
    logic [8:0]    outstanding_cnt;
    logic          abort_valid;
    logic [7:0]    abort_tag;
    logic          spurious_cpl;
    logic          idle;

    int vectors = 0;
    int miscompares = 0;

    requester_tag_queue_rp #(.NB_TAGS(NT), .MAX_REPLAY(MR), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rstn(rstn), .srst(srst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_addr(issue_addr), .issue_len(issue_len), .issue_replay(issue_replay),
        .select_tag(select_tag), .select_tag_valid(select_tag_valid),
        .select_tag_done(select_tag_done), .select_replay_cfg(select_replay_cfg),
        .outstanding_cnt(outstanding_cnt), .abort_valid(abort_valid), .abort_tag(abort_tag),
        .spurious_cpl(spurious_cpl), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tag table as arrays, pending replays as an ordered queue of tags
    bit            m_busy [NT];
    logic [AW-1:0] m_addr [NT];
    logic [10:0]   m_len  [NT];
    int            m_rcnt [NT];
    int            m_pend [$];
    bit            m_iv;
    bit            m_rep;
    int            m_tag;
    logic [AW-1:0] m_iaddr;
    logic [10:0]   m_ilen;
    bit            m_abort;
    bit            m_spur;
    int            m_abort_tag;

    task automatic m_reset();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 1'b0;
            m_rcnt[i] = 0;
        end
        m_pend.delete();
        m_iv = 1'b0; m_rep = 1'b0; m_tag = 0; m_iaddr = '0; m_ilen = '0;
        m_abort = 1'b0; m_spur = 1'b0; m_abort_tag = 0;
    endtask

    function automatic int m_out();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit m_pending(int t);
        foreach (m_pend[i]) if (m_pend[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_req_ready();
        return (!m_iv || issue_ready) && (m_pend.size() == 0) && (m_lowest_free() >= 0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then advance the model and the clock by one cycle
    task automatic tick();
        bit sf;
        bit acc;
        bit pop;
        int ft;
        int hd;
        int t;
        #1;
        chk("req_ready", 64'(req_ready), 64'(m_req_ready()));
        chk("issue_valid", 64'(issue_valid), 64'(m_iv));
        if (m_iv) begin
            chk("issue_tag", 64'(issue_tag), 64'(m_tag));
            chk("issue_addr", issue_addr, m_iaddr);
            chk("issue_len", 64'(issue_len), 64'(m_ilen));
            chk("issue_replay", 64'(issue_replay), 64'(m_rep));
        end
        chk("outstanding_cnt", 64'(outstanding_cnt), 64'(m_out()));
        chk("abort_valid", 64'(abort_valid), 64'(m_abort));
        if (m_abort) chk("abort_tag", 64'(abort_tag), 64'(m_abort_tag));
        chk("spurious_cpl", 64'(spurious_cpl), 64'(m_spur));
        chk("idle", 64'(idle), 64'((m_out() == 0) && !m_iv));

        if (srst) begin
            m_reset();
        end else begin
            sf  = !m_iv || issue_ready;
            acc = req_valid && m_req_ready();
            ft  = m_lowest_free();
            pop = sf && (m_pend.size() != 0);
            hd  = pop ? m_pend.pop_front() : 0;
            m_abort = 1'b0;
            m_spur  = 1'b0;
            if (select_tag_valid) begin
                t = int'(select_tag);
                if (t >= NT || !m_busy[t]) begin
                    m_spur = 1'b1;
                end else if (select_replay_cfg) begin
                    if (m_rcnt[t] == MR) begin
                        m_busy[t] = 1'b0; m_rcnt[t] = 0;
                        m_abort = 1'b1; m_abort_tag = t;
                    end else begin
                        m_rcnt[t]++;
                        if (!m_pending(t)) m_pend.push_back(t);
                    end
                end else if (select_tag_done) begin
                    m_busy[t] = 1'b0; m_rcnt[t] = 0;
                end
            end
            if (sf) begin
                if (pop) begin
                    m_iv = 1'b1; m_tag = hd; m_iaddr = m_addr[hd]; m_ilen = m_len[hd]; m_rep = 1'b1;
                end else if (acc) begin
                    m_iv = 1'b1; m_tag = ft; m_iaddr = req_addr; m_ilen = req_len; m_rep = 1'b0;
                end else begin
                    m_iv = 1'b0;
                end
            end
            if (acc) begin
                m_busy[ft] = 1'b1; m_addr[ft] = req_addr; m_len[ft] = req_len;
            end
        end
        @(posedge clk);
        @(negedge clk);
        select_tag_valid = 1'b0;
    endtask

    task automatic cpl(input int t, input bit err, input bit done);
        select_tag = 8'(t);
        select_replay_cfg = err;
        select_tag_done = done;
        select_tag_valid = 1'b1;
        tick();
    endtask

    initial begin
        int elig [$];
        int pick;
        int last_tag;
        int outs;

        rstn = 1'b0; srst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = 11'd1;
        issue_ready = 1'b1; select_tag = '0; select_tag_valid = 1'b0;
        select_tag_done = 1'b0; select_replay_cfg = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_outstanding", 64'(outstanding_cnt), 64'(0));
        chk("rst_abort_valid", 64'(abort_valid), 64'(0));
        chk("rst_abort_tag", 64'(abort_tag), 64'(0));
        chk("rst_spurious", 64'(spurious_cpl), 64'(0));
        rstn = 1'b1;

        // Three requests, tags 0..2 in order, one cycle after accept
        req_valid = 1'b1; req_len = 11'd16;
        for (int i = 0; i < 3; i++) begin
            req_addr = 64'(32'h1000 * (i + 1));
            tick();
            chk("first_tag", 64'(issue_tag), 64'(i));
            chk("first_valid", 64'(issue_valid), 64'(1));
        end
        chk("first_outstanding", 64'(outstanding_cnt), 64'(3));

        // Fill the table, then free tag 5 and reuse it
        for (int i = 3; i < NT; i++) begin
            req_addr = 64'(32'h10000 + i * 256);
            tick();
        end
        chk("full_outstanding", 64'(outstanding_cnt), 64'(NT));
        chk("full_ready", 64'(req_ready), 64'(0));
        cpl(5, 1'b0, 1'b1);
        chk("freed_ready", 64'(req_ready), 64'(1));
        tick();
        chk("reuse_tag", 64'(issue_tag), 64'(5));
        chk("reuse_outstanding", 64'(outstanding_cnt), 64'(NT));
        req_valid = 1'b0;

        // Errored completion on tag 2 replays it ahead of a waiting new request
        cpl(10, 1'b0, 1'b1);
        cpl(11, 1'b0, 1'b1);
        cpl(2, 1'b1, 1'b0);
        req_valid = 1'b1; req_addr = 64'h4000;
        #1;
        chk("replay_blocks_req", 64'(req_ready), 64'(0));
        tick();
        chk("replay_tag", 64'(issue_tag), 64'(2));
        chk("replay_addr", issue_addr, 64'h3000);
        chk("replay_flag", 64'(issue_replay), 64'(1));
        issue_ready = 1'b0;
        #1;
        chk("stalled_ready", 64'(req_ready), 64'(0));
        repeat (3) tick();
        issue_ready = 1'b1;
        tick();
        chk("after_replay_tag", 64'(issue_tag), 64'(10));
        chk("after_replay_flag", 64'(issue_replay), 64'(0));
        req_valid = 1'b0;

        // Two more replays of tag 2, then the fourth error aborts it
        for (int k = 0; k < 2; k++) begin
            cpl(2, 1'b1, 1'b0);
            tick();
            chk("rep_tag", 64'(issue_tag), 64'(2));
            chk("rep_flag", 64'(issue_replay), 64'(1));
            tick();
        end
        outs = int'(outstanding_cnt);
        cpl(2, 1'b1, 1'b0);
        chk("abort_pulse", 64'(abort_valid), 64'(1));
        chk("abort_which", 64'(abort_tag), 64'(2));
        chk("abort_outstanding", 64'(outstanding_cnt), 64'(outs - 1));
        tick();

        // Partial completions, then spurious ones
        cpl(7, 1'b0, 1'b0);
        cpl(7, 1'b0, 1'b0);
        chk("partial_outstanding", 64'(outstanding_cnt), 64'(outs - 1));
        cpl(7, 1'b0, 1'b1);
        chk("final_outstanding", 64'(outstanding_cnt), 64'(outs - 2));
        cpl(9, 1'b0, 1'b1);
        cpl(9, 1'b0, 1'b1);
        chk("spur_free_tag", 64'(spurious_cpl), 64'(1));
        chk("spur_outstanding", 64'(outstanding_cnt), 64'(outs - 3));
        cpl(40, 1'b0, 1'b1);
        chk("spur_range", 64'(spurious_cpl), 64'(1));

        // Two errors on a tag while the slot is stalled produce a single replay
        req_valid = 1'b1; tick(); req_valid = 1'b0;
        issue_ready = 1'b0;
        cpl(3, 1'b1, 1'b0);
        cpl(3, 1'b1, 1'b0);
        issue_ready = 1'b1;
        tick();
        chk("dup_replay_tag", 64'(issue_tag), 64'(3));
        tick();
        chk("dup_single", 64'(issue_valid), 64'(0));

        // Randomized traffic against the model; completions avoid tags with a replay still queued
        for (int n = 0; n < 2000; n++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            req_valid   = 1'($urandom_range(0, 1));
            req_addr    = {$urandom, $urandom};
            req_len     = 11'($urandom_range(1, 1024));
            if ($urandom_range(0, 9) < 4) begin
                elig.delete();
                for (int t = 0; t < NT; t++) if (m_busy[t] && !m_pending(t)) elig.push_back(t);
                if (elig.size() != 0 && $urandom_range(0, 4) != 0)
                    pick = elig[$urandom_range(0, elig.size() - 1)];
                else
                    pick = int'($urandom_range(0, NT + 7));
                if (!(pick < NT && m_pending(pick))) begin
                    select_tag        = 8'(pick);
                    select_replay_cfg = ($urandom_range(0, 3) == 0);
                    select_tag_done   = 1'($urandom_range(0, 1));
                    select_tag_valid  = 1'b1;
                end
            end
            tick();
        end

        // Drain, stall a held issue for 10 cycles, then synchronous reset
        req_valid = 1'b0; issue_ready = 1'b1;
        repeat (NT + 4) tick();
        pick = -1;
        for (int t = 0; t < NT; t++) if (pick < 0 && m_busy[t]) pick = t;
        if (pick >= 0) cpl(pick, 1'b0, 1'b1);
        req_valid = 1'b1; req_addr = 64'hABCD_0000; req_len = 11'd64;
        tick();
        req_valid = 1'b0; issue_ready = 1'b0;
        chk("stall_valid", 64'(issue_valid), 64'(1));
        last_tag = m_tag;
        repeat (10) tick();
        chk("stall_addr", issue_addr, 64'hABCD_0000);
        chk("stall_len", 64'(issue_len), 64'(64));
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_valid", 64'(issue_valid), 64'(0));
        chk("srst_outstanding", 64'(outstanding_cnt), 64'(0));
        chk("srst_idle", 64'(idle), 64'(1));
        cpl(last_tag, 1'b0, 1'b1);
        chk("late_spur", 64'(spurious_cpl), 64'(1));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
